uart_tx_control_module: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bps_gen.sv | 49 ++++
 rtl/uart_tx_control_module.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default
// bit period and the parity helper. The receive path imports this too.
package uart_pkg;

    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_BAUD_DIV = 434;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit for a byte: odd -> ~^data, even -> ^data
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// Bit-period counter. Counts 0..BAUD_DIV-1 while enabled and emits a
// one-cycle tick when the count equals TAP. The transmitter leaves TAP at
// the last count (end of bit); a receiver sets TAP to mid-bit for sampling.
module uart_bps_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int TAP      = BAUD_DIV - 1
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic cnt_en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] TAP_C = CW'(TAP);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the end of each bit period
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = cnt_en_i && (cnt_q == TAP_C);

endmodule

// File: rtl/uart_tx_control_module.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity,
// 1 or 2 stop bits. Accepts a byte whenever Tx_Ready, Tx_En_Sig and
// Tx_Start_Sig are all high; Tx_Ready is high in IDLE and in the last cycle
// of the final stop bit, which lets frames run back-to-back with no gap.
module uart_tx_control_module
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Tx_En_Sig,
    input  logic       Tx_Start_Sig,
    input  logic [7:0] Tx_Data,
    output logic       Tx_Ready,
    output logic       Tx_Done_Sig,
    output logic       Tx_Pin_Out
);

    localparam logic HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        pin_q, pin_d;

    logic bit_tick;
    logic final_stop;
    logic accept;

    // Bit timer runs for the whole frame and restarts on every accept
    uart_bps_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_bps (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .cnt_en_i (state_q != ST_IDLE),
        .clr_i    (accept),
        .tick_o   (bit_tick)
    );

    // Ready/done come only from registered state and the counter
    assign final_stop  = (state_q == ST_STOP) && (stop_idx_q == STOP_LAST) && bit_tick;
    assign Tx_Ready    = (state_q == ST_IDLE) || final_stop;
    assign Tx_Done_Sig = final_stop;
    assign accept      = Tx_Ready && Tx_En_Sig && Tx_Start_Sig;
    assign Tx_Pin_Out  = pin_q;

    // Frame sequencer: next state, shift register, indices and next line level
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        pin_d      = pin_q;

        case (state_q)
            ST_IDLE: begin
                pin_d = 1'b1;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    pin_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PAR) begin
                            state_d = ST_PARITY;
                            pin_d   = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            pin_d      = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        pin_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d    = ST_STOP;
                    pin_d      = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        pin_d   = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pin_d   = 1'b1;
            end
        endcase

        // A new byte overrides the above, including in the final stop cycle
        if (accept) begin
            state_d    = ST_START;
            pin_d      = 1'b0;
            shift_d    = Tx_Data;
            par_d      = parity_bit(Tx_Data, PARITY);
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
        end
    end

    // State and datapath registers; reset forces the line high at once
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            pin_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            pin_q      <= pin_d;
        end
    end

endmodule
